// File: rtl/miner_if.sv
// Hash-engine handshake bundle between the miner controller and the engine.
//   hash_req   : controller -> engine, request outstanding
//   hash_nonce : controller -> engine, candidate nonce (stable while hash_req=1)
//   hash_ack   : engine -> controller, one-cycle completion pulse
//   hash_hit   : engine -> controller, result qualifier, valid with hash_ack
interface miner_if;
   localparam int unsigned NONCE_W = 32;

   logic               hash_req;
   logic [NONCE_W-1:0] hash_nonce;
   logic               hash_ack;
   logic               hash_hit;

   modport master (output hash_req, output hash_nonce, input hash_ack, input hash_hit);
   modport slave  (input hash_req, input hash_nonce, output hash_ack, output hash_hit);
endinterface

// File: rtl/miner_ctrl.sv
// Nonce search controller: issues candidate nonces to a hash engine until a
// hit, a one-shot completion, or the nonce space is exhausted.
//   clk, rst_n          : clock, synchronous active-low reset
//   start               : toggle request, any level change starts a search
//   config_use_nonce_in : 1 = first nonce from nonce_in, 0 = NONCE_START
//   config_oneshot      : 1 = hash a single nonce per start event
//   nonce_in            : initial nonce, sampled on the start event
//   hash_if             : engine handshake (master side)
//   nonce               : hit nonce, or last nonce tried
//   done, nonce_found   : search finished / finished on a hit
//   busy                : search in progress (REQ or NEXT)
module miner_ctrl #(
   parameter logic [31:0] NONCE_START = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        config_use_nonce_in,
   input  logic        config_oneshot,
   input  logic [31:0] nonce_in,
   miner_if.master     hash_if,
   output logic [31:0] nonce,
   output logic        done,
   output logic        nonce_found,
   output logic        busy
);
   localparam int unsigned NONCE_W = 32;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] NEXT = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [NONCE_W-1:0] NONCE_MAX = '1;

   logic [1:0]         state_q, state_nx;
   logic               start_d;
   logic [NONCE_W-1:0] cur_q, cur_nx;
   logic               rp_q, rp_nx;
   logic               done_nx, found_nx;
   logic [NONCE_W-1:0] nonce_nx;
   logic               start_ev;
   logic [NONCE_W-1:0] load_nonce;

   assign start_ev   = start ^ start_d;
   assign load_nonce = config_use_nonce_in ? nonce_in : NONCE_START;

   // Candidate nonce is the counter itself, so it is stable while requesting
   assign hash_if.hash_nonce = cur_q;

   // Next-state and next-result logic
   always_comb begin
      state_nx = state_q;
      cur_nx   = cur_q;
      rp_nx    = rp_q;
      done_nx  = done;
      found_nx = nonce_found;
      nonce_nx = nonce;
      case (state_q)
         IDLE, DONE: begin
            if (start_ev) begin
               cur_nx   = load_nonce;
               done_nx  = 1'b0;
               found_nx = 1'b0;
               state_nx = REQ;
            end
         end
         REQ: begin
            if (hash_if.hash_ack) begin
               // A start arriving on the ack edge counts as already pending
               if (rp_q || start_ev) begin
                  cur_nx   = load_nonce;
                  rp_nx    = 1'b0;
                  state_nx = NEXT;
               end else if (hash_if.hash_hit) begin
                  nonce_nx = cur_q;
                  found_nx = 1'b1;
                  done_nx  = 1'b1;
                  state_nx = DONE;
               end else if (config_oneshot || (cur_q == NONCE_MAX)) begin
                  nonce_nx = cur_q;
                  found_nx = 1'b0;
                  done_nx  = 1'b1;
                  state_nx = DONE;
               end else begin
                  cur_nx   = cur_q + NONCE_W'(1);
                  state_nx = NEXT;
               end
            end else if (start_ev) begin
               rp_nx = 1'b1;
            end
         end
         NEXT: begin
            if (start_ev) begin
               rp_nx = 1'b1;
            end
            state_nx = REQ;
         end
         default: state_nx = IDLE;
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         start_d          <= start;
         cur_q            <= '0;
         rp_q             <= 1'b0;
         done             <= 1'b0;
         nonce_found      <= 1'b0;
         nonce            <= '0;
         hash_if.hash_req <= 1'b0;
         busy             <= 1'b0;
      end else begin
         state_q          <= state_nx;
         start_d          <= start;
         cur_q            <= cur_nx;
         rp_q             <= rp_nx;
         done             <= done_nx;
         nonce_found      <= found_nx;
         nonce            <= nonce_nx;
         hash_if.hash_req <= (state_nx == REQ);
         busy             <= (state_nx == REQ) || (state_nx == NEXT);
      end
   end
endmodule

// File: tb/tb_miner_ctrl.sv
// Bench for miner_ctrl: the bench plays the hash engine, a queue holds the
// nonces expected on successive requests, and a vector table drives searches.
module tb_miner_ctrl;
   logic        clk;
   logic        rst_n;
   logic        start;
   logic        config_use_nonce_in;
   logic        config_oneshot;
   logic [31:0] nonce_in;
   logic [31:0] nonce;
   logic        done;
   logic        nonce_found;
   logic        busy;

   miner_if hash_if ();

   miner_ctrl #(.NONCE_START(32'h0000_0000)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .start               (start),
      .config_use_nonce_in (config_use_nonce_in),
      .config_oneshot      (config_oneshot),
      .nonce_in            (nonce_in),
      .hash_if             (hash_if.master),
      .nonce               (nonce),
      .done                (done),
      .nonce_found         (nonce_found),
      .busy                (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        use_in;
      logic        oneshot;
      logic [31:0] nin;
      int          hit_at;
      int          nreq;
      logic        exp_found;
      logic [31:0] exp_nonce;
   } vec_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Wait (bounded) for a request, then check it against the scoreboard
   task automatic wait_req(input int max_wait);
      int          k;
      logic [31:0] e;
      k = 0;
      while (hash_if.hash_req !== 1'b1 && k < max_wait) begin
         @(negedge clk);
         k++;
      end
      if (hash_if.hash_req !== 1'b1) begin
         chk("req_present", {31'd0, hash_if.hash_req}, 32'd1);
      end else if (exp_q.size() == 0) begin
         chk("unexpected_req_nonce", hash_if.hash_nonce, 32'hxxxx_xxxx);
      end else begin
         e = exp_q.pop_front();
         chk("req_nonce", hash_if.hash_nonce, e);
         chk("req_busy", {31'd0, busy}, 32'd1);
         chk("req_done_low", {31'd0, done}, 32'd0);
      end
   endtask

   // Engine response after a random latency; request must drop right after
   task automatic do_ack(input logic hit);
      logic [31:0] held;
      held = hash_if.hash_nonce;
      repeat ($urandom_range(2)) @(negedge clk);
      chk("nonce_stable", hash_if.hash_nonce, held);
      hash_if.hash_ack = 1'b1;
      hash_if.hash_hit = hit;
      @(negedge clk);
      hash_if.hash_ack = 1'b0;
      hash_if.hash_hit = 1'b0;
      chk("req_drop", {31'd0, hash_if.hash_req}, 32'd0);
   endtask

   task automatic chk_result(input string tag, input logic found, input logic [31:0] n);
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_found"}, {31'd0, nonce_found}, {31'd0, found});
      chk({tag, "_nonce"}, nonce, n);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   vec_t vt[5];

   initial begin
      vt[0] = '{use_in: 1'b1, oneshot: 1'b1, nin: 32'h1234_5678, hit_at: -1, nreq: 1,
                exp_found: 1'b0, exp_nonce: 32'h1234_5678};
      vt[1] = '{use_in: 1'b0, oneshot: 1'b0, nin: 32'hDEAD_BEEF, hit_at: 4, nreq: 5,
                exp_found: 1'b1, exp_nonce: 32'h0000_0004};
      vt[2] = '{use_in: 1'b1, oneshot: 1'b0, nin: 32'hFFFF_FFFE, hit_at: -1, nreq: 2,
                exp_found: 1'b0, exp_nonce: 32'hFFFF_FFFF};
      vt[3] = '{use_in: 1'b1, oneshot: 1'b1, nin: 32'h0000_0010, hit_at: 0, nreq: 1,
                exp_found: 1'b1, exp_nonce: 32'h0000_0010};
      vt[4] = '{use_in: 1'b0, oneshot: 1'b1, nin: 32'h0000_0055, hit_at: -1, nreq: 1,
                exp_found: 1'b0, exp_nonce: 32'h0000_0000};

      rst_n = 1'b0;
      start = 1'b0;
      config_use_nonce_in = 1'b0;
      config_oneshot = 1'b0;
      nonce_in = '0;
      hash_if.hash_ack = 1'b0;
      hash_if.hash_hit = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req", {31'd0, hash_if.hash_req}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_found", {31'd0, nonce_found}, 32'd0);
      chk("rst_nonce", nonce, 32'd0);
      chk("rst_hash_nonce", hash_if.hash_nonce, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_no_req", {31'd0, hash_if.hash_req}, 32'd0);

      // Table-driven searches
      foreach (vt[v]) begin
         for (int i = 0; i < vt[v].nreq; i++) begin
            exp_q.push_back(vt[v].use_in ? vt[v].nin + 32'(i) : 32'(i));
         end
         config_use_nonce_in = vt[v].use_in;
         config_oneshot = vt[v].oneshot;
         nonce_in = vt[v].nin;
         start = ~start;
         @(negedge clk);
         for (int i = 0; i < vt[v].nreq; i++) begin
            if (i > 0) @(negedge clk);
            wait_req(i == 0 ? 4 : 0);
            do_ack(i == vt[v].hit_at);
         end
         chk_result($sformatf("vec%0d", v), vt[v].exp_found, vt[v].exp_nonce);
         repeat (3) @(negedge clk);
         chk($sformatf("vec%0d_no_more_req", v), {31'd0, hash_if.hash_req}, 32'd0);
         chk($sformatf("vec%0d_hold_nonce", v), nonce, vt[v].exp_nonce);
         chk($sformatf("vec%0d_queue_empty", v), 32'(exp_q.size()), 32'd0);
      end

      // Restart while waiting on nonce 7: the ack for 7 is discarded
      config_use_nonce_in = 1'b0;
      config_oneshot = 1'b0;
      for (int i = 0; i < 8; i++) exp_q.push_back(32'(i));
      start = ~start;
      @(negedge clk);
      for (int i = 0; i < 7; i++) begin
         wait_req(i == 0 ? 4 : 0);
         do_ack(1'b0);
         @(negedge clk);
      end
      wait_req(0);
      start = ~start;
      config_use_nonce_in = 1'b1;
      nonce_in = 32'd100;
      exp_q.push_back(32'd100);
      @(negedge clk);
      do_ack(1'b1);
      chk("restart_done_low", {31'd0, done}, 32'd0);
      chk("restart_found_low", {31'd0, nonce_found}, 32'd0);
      @(negedge clk);
      wait_req(0);
      do_ack(1'b1);
      chk_result("restart", 1'b1, 32'd100);

      // Start toggled on the very ack edge still restarts
      nonce_in = 32'd200;
      exp_q.push_back(32'd200);
      start = ~start;
      @(negedge clk);
      wait_req(4);
      start = ~start;
      nonce_in = 32'd300;
      exp_q.push_back(32'd300);
      do_ack(1'b1);
      chk("coinc_done_low", {31'd0, done}, 32'd0);
      @(negedge clk);
      wait_req(0);
      do_ack(1'b1);
      chk_result("coinc", 1'b1, 32'd300);

      // Reset in REQ while start toggles; stray ack afterwards is ignored
      nonce_in = 32'd5;
      exp_q.push_back(32'd5);
      start = ~start;
      @(negedge clk);
      wait_req(4);
      start = ~start;
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_req", {31'd0, hash_if.hash_req}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      chk("mid_rst_found", {31'd0, nonce_found}, 32'd0);
      chk("mid_rst_nonce", nonce, 32'd0);
      chk("mid_rst_hash_nonce", hash_if.hash_nonce, 32'd0);
      rst_n = 1'b1;
      hash_if.hash_ack = 1'b1;
      hash_if.hash_hit = 1'b1;
      @(negedge clk);
      hash_if.hash_ack = 1'b0;
      hash_if.hash_hit = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("post_rst_idle", {30'd0, hash_if.hash_req, busy}, 32'd0);
         @(negedge clk);
      end
      chk("post_rst_done", {31'd0, done}, 32'd0);
      config_oneshot = 1'b1;
      nonce_in = 32'd9;
      exp_q.push_back(32'd9);
      start = ~start;
      @(negedge clk);
      wait_req(4);
      do_ack(1'b0);
      chk_result("post_rst", 1'b0, 32'd9);
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/miner_ctrl.md
MINER_CTRL -- requirements
Module: miner_ctrl

Interface
REQ-001 SHALL have parameter NONCE_START, default 32'h0000_0000: first nonce issued when config_use_nonce_in=0.
REQ-002 SHALL have port clk  in  1  single clock; every flop in the block is clocked on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  in  1  toggle request; any level change is one start event.
REQ-005 SHALL have port config_use_nonce_in  in  1  1 = first nonce is nonce_in; 0 = first nonce is NONCE_START.
REQ-006 SHALL have port config_oneshot  in  1  1 = hash exactly one nonce per start event.
REQ-007 SHALL have port nonce_in  in  32  initial nonce, sampled on the start event.
REQ-008 SHALL have port hash_req  out  1  request to hash engine, held high until hash_ack.
REQ-009 SHALL have port hash_nonce  out  32  candidate nonce, stable while hash_req=1.
REQ-010 SHALL have port hash_ack  in  1  one-cycle pulse: engine finished the current request.
REQ-011 SHALL have port hash_hit  in  1  valid only when hash_ack=1; 1 = hash meets target.
REQ-012 SHALL have port nonce  out  32  result nonce: the hit nonce, or the last nonce tried.
REQ-013 SHALL have port done  out  1  level; 1 = search finished.
REQ-014 SHALL have port nonce_found  out  1  level; 1 = the search ended on a hit.
REQ-015 SHALL have port busy  out  1  1 while in state REQ or NEXT.

Function
REQ-016 SHALL detect a start event as start XOR start_d, where start_d is start delayed by one registered cycle.
REQ-017 SHALL implement the states IDLE, REQ, NEXT and DONE; hash_req SHALL be 1 only in REQ.
REQ-018 SHALL, on a start event in IDLE or DONE, do the following on the next edge:
- load cur_nonce from nonce_in or NONCE_START according to config_use_nonce_in;
- clear done and nonce_found;
- enter REQ.
REQ-019 SHALL drive hash_nonce = cur_nonce at all times.
REQ-020 SHALL, in REQ with hash_ack=1 and hash_hit=1, set nonce=cur_nonce, nonce_found=1 and done=1 on the same edge, then enter DONE.
REQ-021 SHALL, in REQ with hash_ack=1, hash_hit=0 and config_oneshot=1, set nonce=cur_nonce, nonce_found=0 and done=1, then enter DONE.
REQ-022 SHALL, in REQ with hash_ack=1, hash_hit=0 and cur_nonce=32'hFFFF_FFFF, end the search as exhausted (nonce=FFFF_FFFF, nonce_found=0, done=1) and enter DONE; the counter SHALL never wrap.
REQ-023 SHALL otherwise, in REQ with hash_ack=1, set cur_nonce=cur_nonce+1 (modulo 2^32) and enter NEXT.
REQ-024 SHALL hold hash_req=0 in NEXT, giving one idle cycle between requests, then enter REQ.
REQ-025 SHALL ignore hash_ack outside REQ.
REQ-026 SHALL, on a start event in REQ or NEXT, set restart_pending and keep the current request outstanding.
REQ-027 SHALL, on the next hash_ack in REQ while restart_pending=1, do the following:
- discard hash_hit;
- reload cur_nonce per REQ-018 using the config values present at that edge;
- clear restart_pending;
- enter NEXT, with done kept at 0.
REQ-028 SHALL treat a start event that coincides with the hash_ack edge as pending, so the restart takes effect.
REQ-029 SHALL hold done, nonce and nonce_found stable from the cycle done rises until the next start event.
REQ-030 SHALL update done, nonce and nonce_found on the same edge, so that a downstream capture on a done edge sees consistent values.

Reset
REQ-031 SHALL, while rst_n=0 at a clock edge, enter IDLE and clear the following to 0: hash_req, busy, done, nonce_found, nonce, cur_nonce, restart_pending.
REQ-032 SHALL load start_d from start during reset, so that deasserting reset generates no spurious start event.
REQ-033 SHALL abandon any outstanding request on reset, and SHALL ignore an engine ack arriving after reset.

Verification
REQ-034 Oneshot: use_nonce_in=1, nonce_in=32'h1234_5678, toggle start, ack with hit=0 -> hash_nonce=1234_5678 while hash_req=1; done=1, found=0, nonce=1234_5678.
REQ-035 Search: use_nonce_in=0, oneshot=0, hit=0 on the first 4 acks, hit=1 on the 5th -> nonces 0,1,2,3,4 issued, hash_req low 1 cycle between each; done=1, found=1, nonce=4.
REQ-036 Exhaustion: nonce_in=FFFF_FFFE, hit=0 always -> exactly 2 requests; done=1, found=0, nonce=FFFF_FFFF; no request with nonce 0.
REQ-037 Restart: toggle start while waiting on nonce 7, change nonce_in to 100 -> ack for 7 discarded, done stays 0, next request uses nonce 100.
REQ-038 Reset: pull rst_n low in REQ while start is toggled -> all outputs 0, state IDLE; after release no request until start changes.
